fp_sum_sequencer: RTL and testbench

Initiator-side controller for the single-precision float adder's stb/ack operand/result protocol. It accepts a stream of N IEEE-754 binary32 values over a stb/ack input port and drives the external adder to form their running sum. It returns one binary32 total per N-element group on a stb/ack output port. Used as the softmax denominator accumulator in front of the divider.

---
 rtl/fp_sum_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fp_sum_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sum_sequencer.sv
// Sums groups of N binary32 values by sequencing an external stb/ack float adder.
// Optional build macro FP_SUM_ZERO_SKIP_EN absorbs +/-0 elements without an adder transaction.
module fp_sum_sequencer #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_stb,
  output logic        in_ack,
  output logic [31:0] adder_a,
  output logic [31:0] adder_b,
  output logic        adder_a_stb,
  output logic        adder_b_stb,
  input  logic        adder_a_ack,
  input  logic        adder_b_ack,
  input  logic [31:0] adder_z,
  input  logic        adder_z_stb,
  output logic        adder_z_ack,
  output logic [31:0] sum_z,
  output logic        sum_stb,
  input  logic        sum_ack
);

  // Every channel transfers on a rising edge where its stb and ack are both 1.
  typedef enum logic [2:0] {
    S_FIRST  = 3'd0,
    S_GET    = 3'd1,
    S_SEND   = 3'd2,
    S_WAIT_Z = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  localparam logic [CW-1:0] N_CW = CW'(N);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        in_ack_q, in_ack_d;
  logic [31:0] adder_a_q, adder_a_d;
  logic [31:0] adder_b_q, adder_b_d;
  logic        a_stb_q, a_stb_d;
  logic        b_stb_q, b_stb_d;
  logic        z_ack_q, z_ack_d;
  logic [31:0] sum_z_q, sum_z_d;
  logic        sum_stb_q, sum_stb_d;

  logic          in_fire;
  logic          skip_zero;
  logic [CW-1:0] cnt_inc;

  assign in_fire = in_stb & in_ack_q;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef FP_SUM_ZERO_SKIP_EN
  assign skip_zero = (in_data[30:0] == 31'd0);
`else
  assign skip_zero = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    adder_a_d = adder_a_q;
    adder_b_d = adder_b_q;
    a_stb_d   = a_stb_q;
    b_stb_d   = b_stb_q;
    z_ack_d   = z_ack_q;
    sum_z_d   = sum_z_q;
    sum_stb_d = sum_stb_q;
    case (state_q)
      S_FIRST: begin
        if (in_fire) begin
          acc_d   = in_data;
          cnt_d   = CW'(1);
          state_d = (N == 1) ? S_EMIT : S_GET;
        end
      end
      S_GET: begin
        if (in_fire) begin
          cnt_d = cnt_inc;
          if (skip_zero) begin
            state_d = (cnt_inc == N_CW) ? S_EMIT : S_GET;
          end else begin
            adder_a_d = acc_q;
            adder_b_d = in_data;
            a_stb_d   = 1'b1;
            b_stb_d   = 1'b1;
            state_d   = S_SEND;
          end
        end
      end
      S_SEND: begin
        // Operands are released independently; the result is requested once both are gone.
        a_stb_d = a_stb_q & ~adder_a_ack;
        b_stb_d = b_stb_q & ~adder_b_ack;
        if (!a_stb_d && !b_stb_d) begin
          z_ack_d = 1'b1;
          state_d = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        if (adder_z_stb && z_ack_q) begin
          acc_d   = adder_z;
          z_ack_d = 1'b0;
          state_d = (cnt_q == N_CW) ? S_EMIT : S_GET;
        end
      end
      S_EMIT: begin
        if (!sum_stb_q) begin
          sum_z_d   = acc_q;
          sum_stb_d = 1'b1;
        end else if (sum_ack) begin
          sum_stb_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_FIRST;
        end
      end
      default: state_d = S_FIRST;
    endcase
    // in_ack is registered, so it follows the state being entered.
    in_ack_d = (state_d == S_FIRST) || (state_d == S_GET);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FIRST;
      acc_q     <= '0;
      cnt_q     <= '0;
      in_ack_q  <= 1'b0;
      adder_a_q <= '0;
      adder_b_q <= '0;
      a_stb_q   <= 1'b0;
      b_stb_q   <= 1'b0;
      z_ack_q   <= 1'b0;
      sum_z_q   <= '0;
      sum_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      in_ack_q  <= in_ack_d;
      adder_a_q <= adder_a_d;
      adder_b_q <= adder_b_d;
      a_stb_q   <= a_stb_d;
      b_stb_q   <= b_stb_d;
      z_ack_q   <= z_ack_d;
      sum_z_q   <= sum_z_d;
      sum_stb_q <= sum_stb_d;
    end
  end

  assign in_ack      = in_ack_q;
  assign adder_a     = adder_a_q;
  assign adder_b     = adder_b_q;
  assign adder_a_stb = a_stb_q;
  assign adder_b_stb = b_stb_q;
  assign adder_z_ack = z_ack_q;
  assign sum_z       = sum_z_q;
  assign sum_stb     = sum_stb_q;

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// Bench for fp_sum_sequencer (N=4) with a stand-in adder and a transaction-level sum model.
module tb_fp_sum_sequencer;
  localparam int N = 4;
`ifdef FP_SUM_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_stb, in_ack;
  logic [31:0] adder_a, adder_b, adder_z, sum_z;
  logic        adder_a_stb, adder_b_stb, adder_a_ack, adder_b_ack;
  logic        adder_z_stb, adder_z_ack, sum_stb, sum_ack;

  always #5 clk = ~clk;

  fp_sum_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .adder_a(adder_a), .adder_b(adder_b),
    .adder_a_stb(adder_a_stb), .adder_b_stb(adder_b_stb),
    .adder_a_ack(adder_a_ack), .adder_b_ack(adder_b_ack),
    .adder_z(adder_z), .adder_z_stb(adder_z_stb), .adder_z_ack(adder_z_ack),
    .sum_z(sum_z), .sum_stb(sum_stb), .sum_ack(sum_ack)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [63:0] exp_op_q[$];
  logic [31:0] in_q[$];

  logic [31:0] m_acc = '0;
  int          m_cnt = 0;

  bit          a_got = 0, b_got = 0, lat_run = 0;
  logic [31:0] a_val = '0, b_val = '0;
  int          lat = 0, b_wait = 0;

  int ack_pct = 100, in_pct = 100, lat_min = 0, lat_max = 0, sum_hold = 0;
  bit stagger = 0, do_reset = 0;
  int sums_seen = 0, z_xfers = 0;
  logic [31:0] last_sum = '0;

  bit rst_prev = 1, rst_prev2 = 1;
  bit in_fire_p = 0, z_fire_p = 0, a_fire_p = 0, b_fire_p = 0;
  bit a_wait_p = 0, b_wait_p = 0, pair_done_p = 0, hold_p = 0;
  logic [31:0] held_z = '0;

  // Stand-in adder: exact results for the hand-checked pairs, a scrambler otherwise.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3f800000, 32'h3f800000}: return 32'h40000000;
      {32'h40000000, 32'h3f800000}: return 32'h40400000;
      {32'h40400000, 32'h3f800000}: return 32'h40800000;
      {32'h3f000000, 32'hbf000000}: return 32'h00000000;
      {32'h00000000, 32'h00000000}: return 32'h00000000;
      {32'h3f800000, 32'h00000000}: return 32'h3f800000;
      {32'h40000000, 32'h00000000}: return 32'h40000000;
      default: return (a ^ {b[15:0], b[31:16]}) + 32'h9e3779b9;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: running sum of a group; the first element seeds it, zeros may be absorbed.
  task automatic model_elem(input logic [31:0] e);
    if (m_cnt == 0) begin
      m_acc = e;
    end else if (!(SKIP && e[30:0] == 31'd0)) begin
      exp_op_q.push_back({m_acc, e});
      m_acc = fadd(m_acc, e);
    end
    m_cnt++;
    if (m_cnt == N) begin
      exp_q.push_back(m_acc);
      m_cnt = 0;
    end
  endtask

  task automatic flush();
    m_cnt = 0;
    exp_q.delete();
    exp_op_q.delete();
    in_q.delete();
    a_got = 0; b_got = 0; lat_run = 0;
    in_stb = 1'b0;
    adder_z_stb = 1'b0;
  endtask

  task automatic cycle();
    bit in_fire, a_fire, b_fire, z_fire, s_fire;
    @(negedge clk);
    if (!rst_prev) begin
      check("rst_in_ack", 64'(in_ack), 64'd0);
      check("rst_adder_a", 64'(adder_a), 64'd0);
      check("rst_adder_b", 64'(adder_b), 64'd0);
      check("rst_a_stb", 64'(adder_a_stb), 64'd0);
      check("rst_b_stb", 64'(adder_b_stb), 64'd0);
      check("rst_z_ack", 64'(adder_z_ack), 64'd0);
      check("rst_sum_z", 64'(sum_z), 64'd0);
      check("rst_sum_stb", 64'(sum_stb), 64'd0);
    end else begin
      if (!rst_prev2) check("in_ack_after_rst", 64'(in_ack), 64'd1);
      if (hold_p) begin
        check("sum_stb_hold", 64'(sum_stb), 64'd1);
        check("sum_z_hold", 64'(sum_z), 64'(held_z));
      end
      if (a_fire_p) check("a_stb_clear", 64'(adder_a_stb), 64'd0);
      if (b_fire_p) check("b_stb_clear", 64'(adder_b_stb), 64'd0);
      if (a_wait_p) check("a_stb_held", 64'(adder_a_stb), 64'd1);
      if (b_wait_p) check("b_stb_held", 64'(adder_b_stb), 64'd1);
      if (pair_done_p) check("z_ack_rise", 64'(adder_z_ack), 64'd1);
      if (z_fire_p) check("z_ack_fall", 64'(adder_z_ack), 64'd0);
      check("in_ack_excl", 64'(in_ack & (sum_stb | adder_a_stb | adder_b_stb | adder_z_ack)), 64'd0);
    end

    if (in_fire_p) in_stb = 1'b0;
    if (z_fire_p) adder_z_stb = 1'b0;
    if (lat_run) begin
      if (lat == 0) begin
        adder_z_stb = 1'b1;
        adder_z = fadd(a_val, b_val);
        lat_run = 0;
      end else begin
        lat--;
      end
    end
    if (!in_stb && in_q.size() > 0 && int'($urandom_range(99)) < in_pct) begin
      in_stb = 1'b1;
      in_data = in_q.pop_front();
    end
    if (a_got && !b_got) b_wait++;
    if (stagger) begin
      adder_a_ack = 1'b1;
      adder_b_ack = a_got && (b_wait >= 3);
    end else begin
      adder_a_ack = int'($urandom_range(99)) < ack_pct;
      adder_b_ack = int'($urandom_range(99)) < ack_pct;
    end
    if (sum_hold > 0 && sum_stb) begin
      sum_ack = 1'b0;
      sum_hold--;
    end else begin
      sum_ack = int'($urandom_range(99)) < ack_pct;
    end
    rst = !do_reset;

    in_fire = rst && in_stb && in_ack;
    a_fire  = rst && adder_a_stb && adder_a_ack;
    b_fire  = rst && adder_b_stb && adder_b_ack;
    z_fire  = rst && adder_z_stb && adder_z_ack;
    s_fire  = rst && sum_stb && sum_ack;
    hold_p  = rst && sum_stb && !sum_ack;
    held_z  = sum_z;
    a_wait_p = rst && adder_a_stb && !adder_a_ack;
    b_wait_p = rst && adder_b_stb && !adder_b_ack;
    pair_done_p = 0;
    if (!rst) begin
      flush();
    end else begin
      if (in_fire) model_elem(in_data);
      if (a_fire) begin a_got = 1; a_val = adder_a; b_wait = 0; end
      if (b_fire) begin b_got = 1; b_val = adder_b; end
      if ((a_fire || b_fire) && a_got && b_got) begin
        pair_done_p = 1;
        check("op_expected", 64'(exp_op_q.size() > 0), 64'd1);
        if (exp_op_q.size() > 0) check("adder_operands", {a_val, b_val}, exp_op_q.pop_front());
        lat = int'($urandom_range(lat_max, lat_min));
        lat_run = 1;
        a_got = 0; b_got = 0;
      end
      if (z_fire) z_xfers++;
      if (s_fire) begin
        check("sum_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("sum_z", 64'(sum_z), 64'(exp_q.pop_front()));
        last_sum = sum_z;
        sums_seen++;
      end
    end
    in_fire_p = in_fire; z_fire_p = z_fire; a_fire_p = a_fire; b_fire_p = b_fire;
    rst_prev2 = rst_prev;
    rst_prev = rst;
  endtask

  task automatic run_sums(input int target, input int budget);
    int k = 0;
    while (sums_seen < target && k < budget) begin
      cycle();
      k++;
    end
    check("sum_arrival", 64'(sums_seen), 64'(target));
  endtask

  task automatic push4(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    in_q.push_back(e0); in_q.push_back(e1); in_q.push_back(e2); in_q.push_back(e3);
  endtask

  initial begin
    int z0;
    int k;
    logic [31:0] r;
    rst = 1'b0; in_stb = 1'b0; in_data = '0;
    adder_a_ack = 1'b0; adder_b_ack = 1'b0; adder_z = '0; adder_z_stb = 1'b0; sum_ack = 1'b0;
    do_reset = 1;
    repeat (3) cycle();
    do_reset = 0;

    z0 = z_xfers;
    push4(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000);
    run_sums(sums_seen + 1, 200);
    check("lit_ones_sum", 64'(last_sum), 64'h40800000);
    check("lit_ones_adds", 64'(z_xfers - z0), 64'd3);

    z0 = z_xfers;
    push4(32'h3f000000, 32'hbf000000, 32'h00000000, 32'h00000000);
    run_sums(sums_seen + 1, 200);
    check("lit_cancel_sum", 64'(last_sum), 64'h00000000);
    check("lit_cancel_adds", 64'(z_xfers - z0), SKIP ? 64'd1 : 64'd3);

    z0 = z_xfers;
    push4(32'h3f800000, 32'h00000000, 32'h3f800000, 32'h00000000);
    run_sums(sums_seen + 1, 200);
    check("lit_zero_sum", 64'(last_sum), 64'h40000000);
    check("lit_zero_adds", 64'(z_xfers - z0), SKIP ? 64'd1 : 64'd3);

    stagger = 1;
    push4($urandom | 32'h00800000, $urandom | 32'h00800000,
          $urandom | 32'h00800000, $urandom | 32'h00800000);
    run_sums(sums_seen + 1, 300);
    stagger = 0;

    sum_hold = 5;
    push4($urandom | 32'h00800000, $urandom | 32'h00800000,
          $urandom | 32'h00800000, $urandom | 32'h00800000);
    run_sums(sums_seen + 1, 300);
    check("bp_hold_used", 64'(sum_hold), 64'd0);

    lat_min = 6; lat_max = 6;
    push4(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000);
    k = 0;
    while (!adder_z_ack && k < 200) begin cycle(); k++; end
    check("reach_wait_z", 64'(adder_z_ack), 64'd1);
    do_reset = 1;
    cycle();
    do_reset = 0;
    cycle();
    cycle();
    lat_min = 0; lat_max = 0;
    push4(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000);
    run_sums(sums_seen + 1, 200);
    check("post_rst_sum", 64'(last_sum), 64'h40800000);

    ack_pct = 60; in_pct = 70; lat_max = 3;
    for (int g = 0; g < 30; g++) begin
      for (int e = 0; e < N; e++) begin
        if ($urandom_range(4) == 0) r = ($urandom_range(1) != 0) ? 32'h80000000 : 32'h00000000;
        else r = $urandom;
        in_q.push_back(r);
      end
    end
    run_sums(sums_seen + 30, 30 * 200);
    repeat (5) cycle();
    check("sum_q_empty", 64'(exp_q.size()), 64'd0);
    check("op_q_empty", 64'(exp_op_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
